srio_swrite_arb: RTL and testbench

Packet-granular round-robin arbiter that shares one SRIO SWRITE transmit stream between `N` requesters. Each requester presents a complete 64-bit AXIS packet with its SRIO header word on TUSER. The arbiter grants one port at a time, passes that packet unmodified to the master port, and truncates oversize packets at the SWRITE maximum payload. It sits between the per-channel `srio_swrite_pack` instances and the SRIO core's initiator-request stream.

---
 rtl/srio_swrite_pkg.sv | 29 ++
 rtl/srio_swrite_arb_if.sv | 22 ++
 rtl/srio_rr_pick.sv | 31 +++
 rtl/srio_swrite_arb.sv | 138 +++++++++++++
 tb/tb_srio_swrite_arb.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/srio_swrite_pkg.sv
// srio_swrite_pkg
// Shared definitions for the SRIO SWRITE transmit path: beat limits, bus widths,
// arbiter state encoding and the TUSER header layout used by srio_swrite_pack.
package srio_swrite_pkg;

  // 32 beats x 8 bytes = 256-byte SWRITE payload limit.
  localparam int unsigned SRIO_MAX_BEATS  = 32;
  localparam int unsigned SRIO_DATA_W     = 64;
  localparam int unsigned SRIO_USER_W     = 32;
  localparam int unsigned SRIO_BEAT_CNT_W = 6;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_PASS = 2'd1,
    ARB_DROP = 2'd2
  } arb_state_e;

  // TUSER header: destination ID in the upper half, source ID in the lower half.
  localparam int unsigned HDR_SRC_ID_LSB  = 0;
  localparam int unsigned HDR_SRC_ID_W    = 16;
  localparam int unsigned HDR_DEST_ID_LSB = 16;
  localparam int unsigned HDR_DEST_ID_W   = 16;

  typedef struct packed {
    logic [HDR_DEST_ID_W-1:0] dest_id;
    logic [HDR_SRC_ID_W-1:0]  src_id;
  } srio_hdr_t;

endpackage

// File: rtl/srio_swrite_arb_if.sv
// srio_swrite_arb_if
// Bundle of NP parallel 64-bit AXIS lanes with a 32-bit SRIO header on TUSER.
//   TVALID/TLAST/TREADY : one bit per lane
//   TDATA               : lane i at [64i+63:64i]
//   TUSER               : lane i at [32i+31:32i]
// master drives payload and valid, slave drives ready.
interface srio_swrite_arb_if
  import srio_swrite_pkg::*;
#(
  parameter int unsigned NP = 1
) ();

  logic [NP-1:0]             TVALID;
  logic [NP-1:0]             TREADY;
  logic [SRIO_DATA_W*NP-1:0] TDATA;
  logic [NP-1:0]             TLAST;
  logic [SRIO_USER_W*NP-1:0] TUSER;

  modport master (output TVALID, TDATA, TLAST, TUSER, input TREADY);
  modport slave  (input TVALID, TDATA, TLAST, TUSER, output TREADY);

endinterface

// File: rtl/srio_rr_pick.sv
// srio_rr_pick
// Combinational round-robin selector.
//   req  : request vector, one bit per port
//   last : index of the most recently served port
//   any  : at least one request present
//   idx  : first requesting port at or after last+1 (mod N); holds last when any=0
module srio_rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic                 any,
  output logic [$clog2(N)-1:0] idx
);

  localparam int unsigned IW = $clog2(N);

  logic [IW-1:0] cand;

  // Walk from the farthest candidate back to the nearest so the nearest wins.
  always_comb begin
    any  = |req;
    idx  = last;
    cand = '0;
    for (int unsigned k = N; k > 0; k--) begin
      cand = IW'((32'(last) + k) % N);
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/srio_swrite_arb.sv
// srio_swrite_arb
// Packet-granular round-robin arbiter sharing one SRIO SWRITE AXIS stream among N
// requesters. Packets pass unmodified; packets longer than MAX_BEATS are cut with a
// forced TLAST and the remainder is drained from the source.
//   AXIS_ACLK / AXIS_ARESETN : clock, synchronous active-low reset
//   S_AXIS                   : N requester lanes (arbiter is the slave)
//   M_AXIS                   : single lane toward the SRIO core (arbiter is the master)
//   err / err_clr            : sticky per-port oversize flag and its clear pulse
//   dbug_grant / dbug_busy   : granted port index, valid while busy (PASS or DROP)
module srio_swrite_arb
  import srio_swrite_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter int unsigned MAX_BEATS = SRIO_MAX_BEATS
) (
  input  logic              AXIS_ACLK,
  input  logic              AXIS_ARESETN,
  srio_swrite_arb_if.slave  S_AXIS,
  srio_swrite_arb_if.master M_AXIS,
  output logic [N-1:0]      err,
  input  logic [N-1:0]      err_clr,
  output logic [2:0]        dbug_grant,
  output logic              dbug_busy
);

  localparam int unsigned GW = $clog2(N);
  localparam int unsigned BW = SRIO_BEAT_CNT_W;

  arb_state_e    state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_grant_q, last_grant_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic [N-1:0]  err_q, err_d;

  logic [N-1:0]           s_valid;
  logic [N-1:0]           s_last;
  logic [SRIO_DATA_W-1:0] s_data [N];
  logic [SRIO_USER_W-1:0] s_user [N];

  logic          req_any;
  logic [GW-1:0] pick_idx;
  logic          cap_hit;
  logic [N-1:0]  s_ready_c;
  logic          m_valid_c;
  logic          m_last_c;

  // Split the flat lane buses into per-port views.
  assign s_valid = S_AXIS.TVALID;
  assign s_last  = S_AXIS.TLAST;
  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign s_data[i] = S_AXIS.TDATA[SRIO_DATA_W*i +: SRIO_DATA_W];
    assign s_user[i] = S_AXIS.TUSER[SRIO_USER_W*i +: SRIO_USER_W];
  end

  srio_rr_pick #(.N(N)) u_pick (
    .req  (s_valid),
    .last (last_grant_q),
    .any  (req_any),
    .idx  (pick_idx)
  );

  // Next-state, beat counting, error flags and handshake routing.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    err_d        = err_q & ~err_clr;
    s_ready_c    = '0;
    m_valid_c    = 1'b0;
    m_last_c     = 1'b0;
    cap_hit      = (beat_cnt_q == BW'(MAX_BEATS - 1));

    unique case (state_q)
      ARB_IDLE: begin
        if (req_any) begin
          grant_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = ARB_PASS;
        end
      end
      ARB_PASS: begin
        m_valid_c          = s_valid[grant_q];
        m_last_c           = s_last[grant_q] | cap_hit;
        s_ready_c[grant_q] = M_AXIS.TREADY;
        if (s_valid[grant_q] && M_AXIS.TREADY) begin
          beat_cnt_d = beat_cnt_q + BW'(1);
          if (s_last[grant_q]) begin
            last_grant_d = grant_q;
            state_d      = ARB_IDLE;
          end else if (cap_hit) begin
            // Set after the clear term above so a same-cycle clear loses.
            err_d[grant_q] = 1'b1;
            state_d        = ARB_DROP;
          end
        end
      end
      ARB_DROP: begin
        // Drain the tail of the oversize packet without forwarding it.
        s_ready_c[grant_q] = 1'b1;
        if (s_valid[grant_q] && s_last[grant_q]) begin
          last_grant_d = grant_q;
          state_d      = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge AXIS_ACLK) begin
    if (!AXIS_ARESETN) begin
      state_q      <= ARB_IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(N - 1);
      beat_cnt_q   <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      err_q        <= err_d;
    end
  end

  // Zero-latency master path straight from the granted port.
  assign M_AXIS.TVALID = m_valid_c;
  assign M_AXIS.TDATA  = s_data[grant_q];
  assign M_AXIS.TUSER  = s_user[grant_q];
  assign M_AXIS.TLAST  = m_last_c;
  assign S_AXIS.TREADY = s_ready_c;

  assign err        = err_q;
  assign dbug_grant = 3'(grant_q);
  assign dbug_busy  = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_srio_swrite_arb.sv
// tb_srio_swrite_arb
// Scoreboard bench for srio_swrite_arb: expected master beats are queued in grant
// order as stimulus is launched and popped as the master port hands them off.
module tb_srio_swrite_arb;

  localparam int NPORT = 4;
  localparam int MAXB  = 32;

  typedef struct {
    logic [63:0] data;
    logic [31:0] user;
    logic        last;
    logic        first;
    int          port;
  } beat_t;

  typedef struct {
    int cyc;
    bit last;
  } hs_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m_ready;
  logic        abort;
  logic        src_valid [NPORT];
  logic        src_last  [NPORT];
  logic [63:0] src_data  [NPORT];
  logic [31:0] src_user  [NPORT];
  logic        clr_a     [NPORT];
  logic [NPORT-1:0] err_clr_v;
  logic [NPORT-1:0] err;
  logic [2:0]  dbug_grant;
  logic        dbug_busy;

  int vectors     = 0;
  int miscompares = 0;
  int hs_count    = 0;
  int cyc         = 0;
  beat_t exp_q[$];
  hs_t   hs_log[$];

  srio_swrite_arb_if #(.NP(NPORT)) s_if ();
  srio_swrite_arb_if #(.NP(1))     m_if ();

  srio_swrite_arb #(.N(NPORT), .MAX_BEATS(MAXB)) u_dut (
    .AXIS_ACLK    (clk),
    .AXIS_ARESETN (rst_n),
    .S_AXIS       (s_if.slave),
    .M_AXIS       (m_if.master),
    .err          (err),
    .err_clr      (err_clr_v),
    .dbug_grant   (dbug_grant),
    .dbug_busy    (dbug_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      s_if.TVALID[i]         = src_valid[i];
      s_if.TLAST[i]          = src_last[i];
      s_if.TDATA[64*i +: 64] = src_data[i];
      s_if.TUSER[32*i +: 32] = src_user[i];
      err_clr_v[i]           = clr_a[i];
    end
  end
  assign m_if.TREADY = m_ready;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, expv, $time);
    end
  endtask

  function automatic logic [63:0] gen_data(input int p, input int pkt, input int b);
    return {8'hD0 | 8'(p), 8'(pkt), 16'(b), 32'h5A5A_0000 ^ 32'(p * 4096 + pkt * 256 + b)};
  endfunction

  function automatic logic [31:0] gen_user(input int p, input int pkt);
    return {8'hA5, 8'(p), 8'(pkt), 8'h3C};
  endfunction

  // Queue the beats the master should emit for one packet, truncation included.
  task automatic push_exp(input int p, input int pkt, input int nb, input int emit);
    for (int b = 0; b < emit; b++) begin
      beat_t e;
      e.data  = gen_data(p, pkt, b);
      e.user  = gen_user(p, pkt);
      e.last  = (b == nb - 1) || (b == MAXB - 1);
      e.first = (b == 0);
      e.port  = p;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one packet on port p; clr_beat raises err_clr[p] while that beat is offered.
  task automatic send_pkt(input int p, input int pkt, input int nb, input int clr_beat);
    for (int b = 0; b < nb; b++) begin
      int  guard = 0;
      bit  done  = 0;
      src_valid[p] = 1'b1;
      src_data[p]  = gen_data(p, pkt, b);
      src_user[p]  = gen_user(p, pkt);
      src_last[p]  = (b == nb - 1);
      if (b == clr_beat) clr_a[p] = 1'b1;
      while (!done) begin
        @(negedge clk);
        if (abort) begin
          src_valid[p] = 1'b0;
          src_last[p]  = 1'b0;
          return;
        end
        if (s_if.TREADY[p]) done = 1;
        else begin
          guard++;
          if (guard > 2000) begin
            chk("drv_hs_timeout", 64'(guard), 64'd0);
            src_valid[p] = 1'b0;
            return;
          end
        end
      end
      @(posedge clk);
      #1;
      clr_a[p] = 1'b0;
    end
    src_valid[p] = 1'b0;
    src_last[p]  = 1'b0;
  endtask

  // Master-side monitor: every handshake is checked against the scoreboard.
  always @(negedge clk) begin : mon
    beat_t e;
    hs_t   h;
    if (m_if.TVALID[0] && m_if.TREADY[0]) begin
      hs_count++;
      h.cyc  = cyc;
      h.last = m_if.TLAST[0];
      hs_log.push_back(h);
      chk("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("tdata", m_if.TDATA, e.data);
        chk("tuser", 64'(m_if.TUSER), 64'(e.user));
        chk("tlast", 64'(m_if.TLAST), 64'(e.last));
        if (e.first) chk("grant", 64'(dbug_grant), 64'(e.port));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, expected completion by %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int h0;
    rst_n   = 1'b0;
    m_ready = 1'b0;
    abort   = 1'b0;
    for (int i = 0; i < NPORT; i++) begin
      src_valid[i] = 1'b0;
      src_last[i]  = 1'b0;
      src_data[i]  = '0;
      src_user[i]  = '0;
      clr_a[i]     = 1'b0;
    end
    idle(3);
    chk("rst_busy",   64'(dbug_busy), 64'd0);
    chk("rst_mvalid", 64'(m_if.TVALID), 64'd0);
    chk("rst_sready", 64'(s_if.TREADY), 64'd0);
    chk("rst_err",    64'(err), 64'd0);
    chk("rst_grant",  64'(dbug_grant), 64'd0);
    rst_n   = 1'b1;
    m_ready = 1'b1;

    // Round-robin: all ports request from reset, expected order 0,1,2,3,0.
    hs_log.delete();
    push_exp(0, 0, 2, 2);
    push_exp(1, 0, 2, 2);
    push_exp(2, 0, 2, 2);
    push_exp(3, 0, 2, 2);
    push_exp(0, 1, 2, 2);
    fork
      begin send_pkt(0, 0, 2, -1); send_pkt(0, 1, 2, -1); end
      send_pkt(1, 0, 2, -1);
      send_pkt(2, 0, 2, -1);
      send_pkt(3, 0, 2, -1);
    join
    idle(4);
    chk("rr_drain", 64'(exp_q.size()), 64'd0);
    chk("rr_beats", 64'(hs_log.size()), 64'd10);
    for (int i = 1; i < hs_log.size(); i++)
      if (hs_log[i-1].last) chk("rr_gap", 64'(hs_log[i].cyc - hs_log[i-1].cyc), 64'd2);

    // Backpressure: master ready cycles 1,0,0 while port 2 sends 5 beats.
    push_exp(2, 1, 5, 5);
    fork
      send_pkt(2, 1, 5, -1);
      begin
        int bd   = 0;
        int tail = 0;
        for (int c = 0; c < 60; c++) begin
          m_ready = (c % 3 == 0);
          @(negedge clk);
          chk("bp_other_rdy", 64'(s_if.TREADY & 4'b1011), 64'd0);
          chk("bp_rdy2", 64'(s_if.TREADY[2]), 64'((c >= 1 && bd < 5) ? m_ready : 1'b0));
          if (c >= 1 && bd < 5 && m_ready) bd++;
          @(posedge clk);
          #1;
          if (bd == 5) begin
            tail++;
            if (tail > 2) break;
          end
        end
        chk("bp_beats", 64'(bd), 64'd5);
        m_ready = 1'b1;
      end
    join
    idle(3);
    chk("bp_drain", 64'(exp_q.size()), 64'd0);

    // Exact-size packet is legal.
    push_exp(1, 2, 32, 32);
    send_pkt(1, 2, 32, -1);
    idle(3);
    chk("exact_drain", 64'(exp_q.size()), 64'd0);
    chk("exact_err", 64'(err), 64'd0);

    // Oversize packet: truncated at 32, tail drained, sticky error.
    push_exp(3, 3, 40, 32);
    send_pkt(3, 3, 40, -1);
    idle(2);
    chk("ovr_drain", 64'(exp_q.size()), 64'd0);
    chk("ovr_err", 64'(err), 64'h8);
    idle(5);
    chk("ovr_err_sticky", 64'(err), 64'h8);
    clr_a[3] = 1'b1;
    @(posedge clk);
    #1;
    clr_a[3] = 1'b0;
    chk("ovr_err_clr", 64'(err), 64'd0);
    push_exp(3, 4, 40, 32);
    send_pkt(3, 4, 40, 31);
    idle(2);
    chk("ovr2_drain", 64'(exp_q.size()), 64'd0);
    chk("ovr_set_wins", 64'(err), 64'h8);

    // No preemption: port 1 requests while port 0 is mid-packet.
    hs_log.delete();
    push_exp(0, 5, 4, 4);
    push_exp(1, 5, 2, 2);
    h0 = hs_count;
    fork
      send_pkt(0, 5, 4, -1);
      begin
        int w = 0;
        while (hs_count == h0 && w < 50) begin
          @(posedge clk);
          #1;
          w++;
        end
        send_pkt(1, 5, 2, -1);
      end
    join
    idle(3);
    chk("np_drain", 64'(exp_q.size()), 64'd0);
    chk("np_beats", 64'(hs_log.size()), 64'd6);
    if (hs_log.size() >= 5) chk("np_gap", 64'(hs_log[4].cyc - hs_log[3].cyc), 64'd2);

    // Reset during beat 3 of a port 2 packet.
    push_exp(2, 6, 6, 2);
    h0 = hs_count;
    fork
      send_pkt(2, 6, 6, -1);
      begin
        int w = 0;
        while (hs_count - h0 < 2 && w < 50) begin
          @(posedge clk);
          #1;
          w++;
        end
        m_ready = 1'b0;
        rst_n   = 1'b0;
        abort   = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_busy",   64'(dbug_busy), 64'd0);
        chk("mid_rst_mvalid", 64'(m_if.TVALID), 64'd0);
        chk("mid_rst_sready", 64'(s_if.TREADY), 64'd0);
        chk("mid_rst_err",    64'(err), 64'd0);
        chk("mid_rst_grant",  64'(dbug_grant), 64'd0);
        rst_n   = 1'b1;
        abort   = 1'b0;
        m_ready = 1'b1;
      end
    join
    chk("mid_rst_drain", 64'(exp_q.size()), 64'd0);
    push_exp(0, 7, 3, 3);
    push_exp(2, 7, 3, 3);
    fork
      send_pkt(0, 7, 3, -1);
      send_pkt(2, 7, 3, -1);
    join
    idle(4);
    chk("final_drain", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
